mips_stage_mem_access: RTL and testbench

- Memory stage of the pipelined MIPS core: consumer of the EX→MEM pipeline register and producer of the MEM→WB register.
- Takes ALU result/address, store data and memory control from EX; performs byte/half/word loads and stores through a valid/ready data-memory port.
- Stalls EX while an access is outstanding, and delivers the write-back value (load data or passed-through ALU result).

---
 rtl/mips_stage_mem_access.sv | 196 +++++++++++++++++++
 tb/tb_mips_stage_mem_access.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_stage_mem_access.sv
// MIPS memory stage: takes the EX->MEM register, runs byte/half/word accesses over a
// valid/ready data port and produces the MEM->WB register.
module mips_stage_mem_access #(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              exValid,
    output logic              exReady,
    input  logic [31:0]       exPcAddr,
    input  logic [31:0]       exAluResult,
    input  logic [31:0]       exRegPort2,
    input  logic              exMemRead,
    input  logic              exMemWrite,
    input  logic [1:0]        exMemSize,
    input  logic              exMemSigned,
    input  logic              exRegWrite,
    input  logic [4:0]        exDest,
    output logic              memReqValid,
    input  logic              memReqReady,
    output logic              memReqWrite,
    output logic [ADDR_W-1:0] memAddr,
    output logic [31:0]       memWriteData,
    output logic [3:0]        memByteEnable,
    input  logic              memRespValid,
    input  logic [31:0]       memRespData,
    output logic              wbValid,
    output logic [31:0]       wbPcAddr,
    output logic [31:0]       wbResult,
    output logic [4:0]        wbDest,
    output logic              wbRegWrite,
    output logic              wbException
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

    logic [1:0]  state;
    logic [7:0]  wait_cnt;
    logic [31:0] pc_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic        regwrite_q;
    logic [4:0]  dest_q;
    logic        write_q;

    logic        is_mem;
    logic        misaligned;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [31:0] lane_word;
    logic [31:0] load_value;
    logic        timeout;

    assign exReady = (state == IDLE);
    assign is_mem  = exMemRead | exMemWrite;
    assign timeout = (wait_cnt == LAST_CNT);

    // Size 11 is handled as a word everywhere, including the alignment check.
    always_comb begin
        misaligned = 1'b0;
        req_be     = 4'b1111;
        req_wdata  = exRegPort2;
        case (exMemSize)
            2'b00: begin
                req_be    = 4'b0001 << exAluResult[1:0];
                req_wdata = {4{exRegPort2[7:0]}};
            end
            2'b01: begin
                misaligned = exAluResult[0];
                req_be     = exAluResult[1] ? 4'b1100 : 4'b0011;
                req_wdata  = {2{exRegPort2[15:0]}};
            end
            default: misaligned = |exAluResult[1:0];
        endcase
    end

    // Shift the addressed lane down to bit 0, then extend.
    always_comb begin
        lane_word = memRespData >> {addr_q[1:0], 3'b000};
        case (size_q)
            2'b00:   load_value = {{24{signed_q & lane_word[7]}}, lane_word[7:0]};
            2'b01:   load_value = {{16{signed_q & lane_word[15]}}, lane_word[15:0]};
            default: load_value = lane_word;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            wait_cnt      <= 8'd0;
            pc_q          <= 32'd0;
            addr_q        <= 32'd0;
            size_q        <= 2'd0;
            signed_q      <= 1'b0;
            regwrite_q    <= 1'b0;
            dest_q        <= 5'd0;
            write_q       <= 1'b0;
            memReqValid   <= 1'b0;
            memReqWrite   <= 1'b0;
            memAddr       <= '0;
            memWriteData  <= 32'd0;
            memByteEnable <= 4'd0;
            wbValid       <= 1'b0;
            wbPcAddr      <= 32'd0;
            wbResult      <= 32'd0;
            wbDest        <= 5'd0;
            wbRegWrite    <= 1'b0;
            wbException   <= 1'b0;
        end else begin
            wbValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (exValid) begin
                        if (!is_mem || misaligned) begin
                            wbValid     <= 1'b1;
                            wbPcAddr    <= exPcAddr;
                            wbDest      <= exDest;
                            wbResult    <= exAluResult;
                            wbRegWrite  <= exRegWrite & ~is_mem;
                            wbException <= is_mem;
                        end else begin
                            pc_q          <= exPcAddr;
                            addr_q        <= exAluResult;
                            size_q        <= exMemSize;
                            signed_q      <= exMemSigned;
                            regwrite_q    <= exRegWrite;
                            dest_q        <= exDest;
                            write_q       <= exMemWrite;
                            memReqValid   <= 1'b1;
                            memReqWrite   <= exMemWrite;
                            memAddr       <= {exAluResult[ADDR_W-1:2], 2'b00};
                            memWriteData  <= exMemWrite ? req_wdata : 32'd0;
                            memByteEnable <= req_be;
                            wait_cnt      <= 8'd0;
                            state         <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (memReqReady) begin
                        memReqValid <= 1'b0;
                        wait_cnt    <= 8'd0;
                        if (write_q) begin
                            wbValid     <= 1'b1;
                            wbPcAddr    <= pc_q;
                            wbDest      <= dest_q;
                            wbResult    <= addr_q;
                            wbRegWrite  <= 1'b0;
                            wbException <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (timeout) begin
                        memReqValid <= 1'b0;
                        wbValid     <= 1'b1;
                        wbPcAddr    <= pc_q;
                        wbDest      <= dest_q;
                        wbResult    <= addr_q;
                        wbRegWrite  <= 1'b0;
                        wbException <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                WAIT: begin
                    if (memRespValid) begin
                        wbValid     <= 1'b1;
                        wbPcAddr    <= pc_q;
                        wbDest      <= dest_q;
                        wbResult    <= load_value;
                        wbRegWrite  <= regwrite_q;
                        wbException <= 1'b0;
                        state       <= IDLE;
                    end else if (timeout) begin
                        wbValid     <= 1'b1;
                        wbPcAddr    <= pc_q;
                        wbDest      <= dest_q;
                        wbResult    <= addr_q;
                        wbRegWrite  <= 1'b0;
                        wbException <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_stage_mem_access.sv
// Directed bench for mips_stage_mem_access: a transaction-level model predicts every
// write-back and bus request; a negedge monitor compares the DUT against it.
module tb_mips_stage_mem_access;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        exValid = 1'b0;
    logic        exReady;
    logic [31:0] exPcAddr = 32'd0;
    logic [31:0] exAluResult = 32'd0;
    logic [31:0] exRegPort2 = 32'd0;
    logic        exMemRead = 1'b0;
    logic        exMemWrite = 1'b0;
    logic [1:0]  exMemSize = 2'd0;
    logic        exMemSigned = 1'b0;
    logic        exRegWrite = 1'b0;
    logic [4:0]  exDest = 5'd0;
    logic        memReqValid;
    logic        memReqReady = 1'b0;
    logic        memReqWrite;
    logic [31:0] memAddr;
    logic [31:0] memWriteData;
    logic [3:0]  memByteEnable;
    logic        memRespValid = 1'b0;
    logic [31:0] memRespData = 32'd0;
    logic        wbValid;
    logic [31:0] wbPcAddr;
    logic [31:0] wbResult;
    logic [4:0]  wbDest;
    logic        wbRegWrite;
    logic        wbException;

    mips_stage_mem_access #(.ADDR_W(32), .MAX_WAIT(4)) dut (
        .clock(clock), .reset(reset),
        .exValid(exValid), .exReady(exReady), .exPcAddr(exPcAddr),
        .exAluResult(exAluResult), .exRegPort2(exRegPort2),
        .exMemRead(exMemRead), .exMemWrite(exMemWrite), .exMemSize(exMemSize),
        .exMemSigned(exMemSigned), .exRegWrite(exRegWrite), .exDest(exDest),
        .memReqValid(memReqValid), .memReqReady(memReqReady), .memReqWrite(memReqWrite),
        .memAddr(memAddr), .memWriteData(memWriteData), .memByteEnable(memByteEnable),
        .memRespValid(memRespValid), .memRespData(memRespData),
        .wbValid(wbValid), .wbPcAddr(wbPcAddr), .wbResult(wbResult), .wbDest(wbDest),
        .wbRegWrite(wbRegWrite), .wbException(wbException)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] result;
        logic [4:0]  dest;
        logic        rw;
        logic        exc;
        logic        chk_res;
        logic        lit_en;
        logic [31:0] lit;
    } wb_t;

    wb_t         exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          req_cycles = 0;
    int          wb_pulses = 0;
    logic        req_expected = 1'b0;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    logic        exp_write;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_be;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic is_misaligned(input logic [31:0] a, input logic [1:0] size);
        if (size == 2'd0) return 1'b0;
        if (size == 2'd1) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    // Load value from the rules: shift to the addressed byte, mask to width, extend.
    function automatic logic [31:0] load_model(input logic [31:0] a, input logic [1:0] size,
                                               input logic sgn, input logic [31:0] resp);
        logic [31:0] sh, mask, v;
        int bits;
        sh   = resp >> (8 * (a % 4));
        bits = (size == 2'd0) ? 8 : (size == 2'd1) ? 16 : 32;
        mask = (bits == 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
        v    = sh & mask;
        if (sgn && bits < 32 && sh[bits-1]) v = v | ~mask;
        return v;
    endfunction

    always @(negedge clock) begin
        if (memReqValid === 1'b1) begin
            req_cycles++;
            chk("exready_in_req", {31'd0, exReady}, 32'd0);
            if (!req_expected) begin
                chk("spurious_req", {31'd0, memReqValid}, 32'd0);
            end else begin
                chk("req_addr", memAddr, exp_addr);
                chk("req_be", {28'd0, memByteEnable}, {28'd0, exp_be});
                chk("req_wdata", memWriteData, exp_wdata);
                chk("req_write", {31'd0, memReqWrite}, {31'd0, exp_write});
            end
            last_addr  = memAddr;
            last_be    = memByteEnable;
            last_wdata = memWriteData;
        end
        if (wbValid === 1'b1) begin
            wb_pulses++;
            if (exp_q.size() == 0) begin
                chk("unexpected_wb", {31'd0, wbValid}, 32'd0);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                chk("wb_pc", wbPcAddr, e.pc);
                chk("wb_dest", {27'd0, wbDest}, {27'd0, e.dest});
                chk("wb_regwrite", {31'd0, wbRegWrite}, {31'd0, e.rw});
                chk("wb_exception", {31'd0, wbException}, {31'd0, e.exc});
                if (e.chk_res) chk("wb_result", wbResult, e.result);
                if (e.lit_en) chk("wb_result_literal", wbResult, e.lit);
            end
        end
    end

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle;
        int n = 0;
        while (exReady !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk("wait_idle_timeout", {31'd0, exReady}, 32'd1);
    endtask

    // rdy_dly < 0: memReqReady never rises, so the access must time out.
    task automatic issue(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] data,
                         input logic rd, input logic wr, input logic [1:0] size,
                         input logic sgn, input logic rw, input logic [4:0] dest,
                         input int rdy_dly, input int rsp_dly, input logic [31:0] resp,
                         input logic lit_en, input logic [31:0] lit);
        wb_t e;
        logic mem, mis;
        wait_idle();
        mem = rd | wr;
        mis = mem && is_misaligned(alu, size);
        exPcAddr = pc; exAluResult = alu; exRegPort2 = data;
        exMemRead = rd; exMemWrite = wr; exMemSize = size;
        exMemSigned = sgn; exRegWrite = rw; exDest = dest;
        exValid = 1'b1;
        e.pc = pc; e.dest = dest; e.lit_en = lit_en; e.lit = lit;
        if (!mem) begin
            e.result = alu; e.rw = rw; e.exc = 1'b0; e.chk_res = 1'b1;
        end else if (mis) begin
            e.result = alu; e.rw = 1'b0; e.exc = 1'b1; e.chk_res = 1'b1;
        end else if (rdy_dly < 0) begin
            e.result = 32'd0; e.rw = 1'b0; e.exc = 1'b1; e.chk_res = 1'b0;
        end else if (wr) begin
            e.result = 32'd0; e.rw = 1'b0; e.exc = 1'b0; e.chk_res = 1'b0;
        end else begin
            e.result = load_model(alu, size, sgn, resp); e.rw = rw; e.exc = 1'b0; e.chk_res = 1'b1;
        end
        exp_q.push_back(e);
        if (mem && !mis) begin
            exp_addr  = alu & 32'hFFFF_FFFC;
            exp_write = wr;
            exp_be    = (size == 2'd0) ? 4'(1 << (alu % 4)) :
                        (size == 2'd1) ? 4'(3 << (alu & 2)) : 4'hF;
            exp_wdata = !wr ? 32'd0 :
                        (size == 2'd0) ? (data & 32'hFF) * 32'h0101_0101 :
                        (size == 2'd1) ? (data & 32'hFFFF) * 32'h0001_0001 : data;
            req_expected = 1'b1;
        end
        step();
        exValid = 1'b0;
        if (mem && !mis) begin
            if (rdy_dly < 0) begin
                repeat (6) step();
            end else begin
                repeat (rdy_dly) step();
                memReqReady = 1'b1;
                step();
                memReqReady = 1'b0;
                if (rd) begin
                    repeat (rsp_dly) step();
                    memRespValid = 1'b1;
                    memRespData  = resp;
                    step();
                    memRespValid = 1'b0;
                end
            end
            req_expected = 1'b0;
        end
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clock);
        chk({tag, "_exready"}, {31'd0, exReady}, 32'd1);
        chk({tag, "_wbvalid"}, {31'd0, wbValid}, 32'd0);
        chk({tag, "_wbresult"}, wbResult, 32'd0);
        chk({tag, "_wbpc"}, wbPcAddr, 32'd0);
        chk({tag, "_wbdest"}, {27'd0, wbDest}, 32'd0);
        chk({tag, "_wbregwrite"}, {31'd0, wbRegWrite}, 32'd0);
        chk({tag, "_wbexception"}, {31'd0, wbException}, 32'd0);
        chk({tag, "_memreqvalid"}, {31'd0, memReqValid}, 32'd0);
        chk({tag, "_memaddr"}, memAddr, 32'd0);
        chk({tag, "_membe"}, {28'd0, memByteEnable}, 32'd0);
        chk({tag, "_memwdata"}, memWriteData, 32'd0);
    endtask

    initial begin
        int n;
        int pulses_before;
        reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        check_reset_state("reset");
        step();

        // Non-memory ALU op
        req_cycles = 0;
        issue(32'h100, 32'h1234, 32'h0, 0, 0, 2'd2, 0, 1, 5'd5, 0, 0, 32'h0, 1, 32'h1234);
        step();
        chk("alu_no_req", req_cycles, 0);

        // Store byte 0xAB at 0x1003, ready held off two cycles
        req_cycles = 0;
        issue(32'h104, 32'h1003, 32'h0000_00AB, 0, 1, 2'd0, 0, 1, 5'd6, 2, 0, 32'h0, 0, 32'h0);
        chk("sb_req_cycles", req_cycles, 3);
        chk("sb_addr_literal", last_addr, 32'h1000);
        chk("sb_be_literal", {28'd0, last_be}, 32'h8);
        chk("sb_wdata_literal", last_wdata, 32'hABAB_ABAB);

        // Loads with literal pins
        issue(32'h108, 32'h2002, 32'h0, 1, 0, 2'd1, 1, 1, 5'd7, 0, 0, 32'h8001_0000, 1, 32'hFFFF_8001);
        issue(32'h10C, 32'h2002, 32'h0, 1, 0, 2'd1, 0, 1, 5'd8, 1, 2, 32'h8001_0000, 1, 32'h0000_8001);
        issue(32'h110, 32'h2001, 32'h0, 1, 0, 2'd0, 1, 1, 5'd9, 0, 1, 32'h0000_7F00, 1, 32'h0000_007F);

        // Misaligned word load
        req_cycles = 0;
        issue(32'h114, 32'h3002, 32'h0, 1, 0, 2'd2, 0, 1, 5'd10, 0, 0, 32'h0, 1, 32'h3002);
        step();
        chk("misaligned_no_req", req_cycles, 0);

        // More patterns, issued back to back
        issue(32'h118, 32'h4000, 32'hDEAD_BEEF, 0, 1, 2'd2, 0, 0, 5'd0, 0, 0, 32'h0, 0, 32'h0);
        issue(32'h11C, 32'h4006, 32'h1234_BEEF, 0, 1, 2'd1, 0, 0, 5'd0, 1, 0, 32'h0, 0, 32'h0);
        issue(32'h120, 32'h4003, 32'h0, 1, 0, 2'd0, 1, 1, 5'd11, 0, 0, 32'h8555_5555, 1, 32'hFFFF_FF85);
        issue(32'h124, 32'h4000, 32'h0, 1, 0, 2'd3, 0, 1, 5'd12, 0, 0, 32'hCAFE_F00D, 1, 32'hCAFE_F00D);
        issue(32'h128, 32'h4001, 32'h0, 1, 0, 2'd1, 1, 0, 5'd13, 0, 0, 32'h0, 1, 32'h4001);
        issue(32'h12C, 32'h0000_0099, 32'h0, 0, 0, 2'd0, 0, 0, 5'd14, 0, 0, 32'h0, 0, 32'h0);
        issue(32'h130, 32'h4002, 32'h0, 1, 0, 2'd1, 0, 1, 5'd15, 0, 0, 32'hF00D_0000, 0, 32'h0);

        // Timeout in REQ with MAX_WAIT=4
        req_cycles = 0;
        issue(32'h134, 32'h5000, 32'h0, 1, 0, 2'd2, 0, 1, 5'd16, -1, 0, 32'h0, 0, 32'h0);
        chk("timeout_req_cycles", req_cycles, 4);
        chk("timeout_exready", {31'd0, exReady}, 32'd1);

        // Reset during WAIT abandons the load; a late response must be ignored
        wait_idle();
        exPcAddr = 32'h138; exAluResult = 32'h6000; exMemRead = 1'b1; exMemWrite = 1'b0;
        exMemSize = 2'd2; exMemSigned = 1'b0; exRegWrite = 1'b1; exDest = 5'd17;
        exp_addr = 32'h6000; exp_be = 4'hF; exp_wdata = 32'd0; exp_write = 1'b0;
        req_expected = 1'b1;
        exValid = 1'b1;
        step();
        exValid = 1'b0;
        memReqReady = 1'b1;
        step();
        memReqReady = 1'b0;
        req_expected = 1'b0;
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_reset_state("midwait");
        pulses_before = wb_pulses;
        step();
        memRespValid = 1'b1;
        memRespData  = 32'h1111_2222;
        step();
        memRespValid = 1'b0;
        repeat (3) step();
        chk("late_resp_ignored", wb_pulses, pulses_before);

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
